id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline register for the five-stage core. It carries a valid bit plus WB/MEM/EX control, PC, operands, immediate and register addresses from decode to execute, and supports stall (hold) and flush (bubble) requests. It also contains built-in load-use hazard detection with automatic bubble insertion, a register-file write-through bypass for captured and held operands, and a saturating bubble counter.

## Interface

Parameters:
- DATA_W, 32, width of PC, operand and immediate fields
- REG_AW, 5, register address width
- WB_W, 2, write-back control width
- MEM_W, 2, memory control width
- EX_W, 4, execute control width
- MEM_RD_BIT, 0, index in mem control marking a memory read (load)
- CNT_W, 16, bubble counter width

Ports:
- clk_i, in, 1, clock, rising edge
- rst_n_i, in, 1, asynchronous active-low reset
- stall_i, in, 1, hold all stage contents
- flush_i, in, 1, replace the next stage contents with a bubble
- valid_i, in, 1, decode-stage instruction valid
- wb_i / mem_i / ex_i, in, WB_W / MEM_W / EX_W, decode control fields
- pc_i, rsdata_i, rtdata_i, imm_i, in, DATA_W each, decode data fields
- rsaddr_i, rtaddr_i, rdaddr_i, in, REG_AW each, decode register addresses
- wb_we_i, in, 1, register-file write enable from WB stage
- wb_addr_i, in, REG_AW, register-file write address
- wb_data_i, in, DATA_W, register-file write data
- valid_o, out, 1, stage holds a real instruction
- wb_o / mem_o / ex_o, out, WB_W / MEM_W / EX_W, registered control
- pc_o, rsdata_o, rtdata_o, imm_o, out, DATA_W each, registered data
- funct_o, out, 6, imm_o[5:0]
- rsaddr_o, rtaddr_o, rdaddr_o, out, REG_AW each, registered addresses
- hazard_o, out, 1, load-use hazard (combinational); upstream holds PC and IF/ID
- bubble_cnt_o, out, CNT_W, count of bubbles inserted

## Operation

- **Reset** (rst_n_i low, asynchronous): all registered outputs are 0, including valid_o and bubble_cnt_o.
- **Hazard detection:** hazard_o = valid_o & mem_o[MEM_RD_BIT] & (rtaddr_o != 0) & valid_i & ((rtaddr_o == rsaddr_i) | (rtaddr_o == rtaddr_i)).
- **Per-edge action, highest priority first:**
  - flush_i: insert a bubble.
  - stall_i: hold.
  - hazard_o: insert a bubble.
  - otherwise: load from the decode-stage inputs.
- **Bubble:**
  - valid_o, wb_o, mem_o and ex_o are cleared to 0.
  - Data and address fields keep their previous values and must not be relied on.
  - bubble_cnt_o increments by 1 and saturates at 2^CNT_W−1 with no wrap.
- **Load:**
  - All fields capture their inputs.
  - valid_o captures valid_i.
  - If valid_i is 0, control fields are captured as 0.
- **Write-through bypass on load:**
  - If wb_we_i, wb_addr_i != 0 and wb_addr_i == rsaddr_i, then rsdata_o captures wb_data_i.
  - The same rule applies independently to rtaddr_i → rtdata_o.
- **Bypass on hold** (stall_i, no flush):
  - If valid_o, wb_we_i, wb_addr_i != 0 and wb_addr_i == rsaddr_o, then rsdata_o updates to wb_data_i.
  - The same rule applies for rtaddr_o → rtdata_o.
  - All other fields are held.
- Register address 0 is never hazarded and never bypassed.

## Timing

- Latency is 1 cycle from the decode inputs to the registered outputs.
- hazard_o is combinational from the current outputs and rsaddr_i, rtaddr_i and valid_i.
  - It has no path from stall_i or flush_i.
- A load-use hazard costs exactly one bubble.
  - After the bubble, valid_o = 0, so hazard_o drops and the held decode instruction loads on the next edge.
- Stall with hazard asserted: stall wins and the stage holds. hazard_o stays high until the stall releases, then one bubble is inserted.
- Flush and stall together: flush wins, a bubble is inserted and counted.
- Flush with hazard asserted: one bubble, counted once.
- Reset asserted mid-stall or mid-bubble clears the stage immediately. First load occurs on the first edge after rst_n_i rises.

## Test plan

- **Reset:** drive all inputs nonzero and pulse rst_n_i low between edges → all outputs 0 immediately. After release with valid_i=1 and pc_i=0x40, next edge gives pc_o=0x40 and valid_o=1.
- **Load-use:**
  - Stage holds a load (mem_o[0]=1) with rtaddr_o=5; decode presents rsaddr_i=5, valid_i=1.
  - Expected: hazard_o=1; next edge gives valid_o=0, ex_o=0, bubble_cnt_o=1; the following edge loads the decode instruction.
  - Repeat with rtaddr_o=0 → hazard_o=0.
- **Stall hold:** stall_i=1 for 3 cycles with changing inputs → all outputs are constant and bubble_cnt_o is unchanged.
- **Bypass:**
  - Load with rsaddr_i=7, rsdata_i=0x11, and wb_we_i=1, wb_addr_i=7, wb_data_i=0xAB in the same cycle → rsdata_o=0xAB.
  - During a stall, a WB write of 0xCD to rtaddr_o → rtdata_o=0xCD.
  - A write to address 0 → no change.
- **Priority:**
  - flush_i=1 with stall_i=1 and a hazard present → one bubble, bubble_cnt_o increments by exactly 1.
  - stall_i=1 with a hazard present → hold, no count.
- **Saturation:** with CNT_W=2, issue 5 flushes → bubble_cnt_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: stall/flush control, load-use bubble insertion,
// register-file write-through bypass for captured and held operands, bubble counter.
module id_ex_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int WB_W       = 2,
   parameter int MEM_W      = 2,
   parameter int EX_W       = 4,
   parameter int MEM_RD_BIT = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [WB_W-1:0]   wb_i,
   input  logic [MEM_W-1:0]  mem_i,
   input  logic [EX_W-1:0]   ex_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] rsdata_i,
   input  logic [DATA_W-1:0] rtdata_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [REG_AW-1:0] rsaddr_i,
   input  logic [REG_AW-1:0] rtaddr_i,
   input  logic [REG_AW-1:0] rdaddr_i,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic              valid_o,
   output logic [WB_W-1:0]   wb_o,
   output logic [MEM_W-1:0]  mem_o,
   output logic [EX_W-1:0]   ex_o,
   output logic [DATA_W-1:0] pc_o,
   output logic [DATA_W-1:0] rsdata_o,
   output logic [DATA_W-1:0] rtdata_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [5:0]        funct_o,
   output logic [REG_AW-1:0] rsaddr_o,
   output logic [REG_AW-1:0] rtaddr_o,
   output logic [REG_AW-1:0] rdaddr_o,
   output logic              hazard_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              valid_q,  valid_d;
   logic [WB_W-1:0]   wb_q,     wb_d;
   logic [MEM_W-1:0]  mem_q,    mem_d;
   logic [EX_W-1:0]   ex_q,     ex_d;
   logic [DATA_W-1:0] pc_q,     pc_d;
   logic [DATA_W-1:0] rsdata_q, rsdata_d;
   logic [DATA_W-1:0] rtdata_q, rtdata_d;
   logic [DATA_W-1:0] imm_q,    imm_d;
   logic [REG_AW-1:0] rsaddr_q, rsaddr_d;
   logic [REG_AW-1:0] rtaddr_q, rtaddr_d;
   logic [REG_AW-1:0] rdaddr_q, rdaddr_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   logic hazard;
   logic bubble;
   logic wb_hit;
   logic rs_fwd_ld, rt_fwd_ld;
   logic rs_fwd_hold, rt_fwd_hold;

   // Load in EX whose destination is a source of the decode instruction.
   assign hazard = valid_q & mem_q[MEM_RD_BIT] & (rtaddr_q != '0) & valid_i &
                   ((rtaddr_q == rsaddr_i) | (rtaddr_q == rtaddr_i));

   assign bubble      = flush_i | (~stall_i & hazard);
   assign wb_hit      = wb_we_i & (wb_addr_i != '0);
   assign rs_fwd_ld   = wb_hit & (wb_addr_i == rsaddr_i);
   assign rt_fwd_ld   = wb_hit & (wb_addr_i == rtaddr_i);
   assign rs_fwd_hold = valid_q & wb_hit & (wb_addr_i == rsaddr_q);
   assign rt_fwd_hold = valid_q & wb_hit & (wb_addr_i == rtaddr_q);

   always_comb begin
      valid_d  = valid_q;
      wb_d     = wb_q;
      mem_d    = mem_q;
      ex_d     = ex_q;
      pc_d     = pc_q;
      rsdata_d = rsdata_q;
      rtdata_d = rtdata_q;
      imm_d    = imm_q;
      rsaddr_d = rsaddr_q;
      rtaddr_d = rtaddr_q;
      rdaddr_d = rdaddr_q;
      cnt_d    = cnt_q;
      if (bubble) begin
         // Data/address fields are left as-is; only control is cleared.
         valid_d = 1'b0;
         wb_d    = '0;
         mem_d   = '0;
         ex_d    = '0;
         if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (stall_i) begin
         if (rs_fwd_hold) begin
            rsdata_d = wb_data_i;
         end
         if (rt_fwd_hold) begin
            rtdata_d = wb_data_i;
         end
      end else begin
         valid_d  = valid_i;
         wb_d     = valid_i ? wb_i  : '0;
         mem_d    = valid_i ? mem_i : '0;
         ex_d     = valid_i ? ex_i  : '0;
         pc_d     = pc_i;
         rsdata_d = rs_fwd_ld ? wb_data_i : rsdata_i;
         rtdata_d = rt_fwd_ld ? wb_data_i : rtdata_i;
         imm_d    = imm_i;
         rsaddr_d = rsaddr_i;
         rtaddr_d = rtaddr_i;
         rdaddr_d = rdaddr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q  <= 1'b0;
         wb_q     <= '0;
         mem_q    <= '0;
         ex_q     <= '0;
         pc_q     <= '0;
         rsdata_q <= '0;
         rtdata_q <= '0;
         imm_q    <= '0;
         rsaddr_q <= '0;
         rtaddr_q <= '0;
         rdaddr_q <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         wb_q     <= wb_d;
         mem_q    <= mem_d;
         ex_q     <= ex_d;
         pc_q     <= pc_d;
         rsdata_q <= rsdata_d;
         rtdata_q <= rtdata_d;
         imm_q    <= imm_d;
         rsaddr_q <= rsaddr_d;
         rtaddr_q <= rtaddr_d;
         rdaddr_q <= rdaddr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign wb_o         = wb_q;
   assign mem_o        = mem_q;
   assign ex_o         = ex_q;
   assign pc_o         = pc_q;
   assign rsdata_o     = rsdata_q;
   assign rtdata_o     = rtdata_q;
   assign imm_o        = imm_q;
   assign funct_o      = imm_q[5:0];
   assign rsaddr_o     = rsaddr_q;
   assign rtaddr_o     = rtaddr_q;
   assign rdaddr_o     = rdaddr_q;
   assign hazard_o     = hazard;
   assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the stage's documented behaviour.
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, flush, vld;
   logic [1:0]        wb, mem;
   logic [3:0]        ex;
   logic [DATA_W-1:0] pc, rsd, rtd, imm;
   logic [REG_AW-1:0] rsa, rta, rda;
   logic              we;
   logic [REG_AW-1:0] wa;
   logic [DATA_W-1:0] wd;

   logic              valid_o;
   logic [1:0]        wb_o, mem_o;
   logic [3:0]        ex_o;
   logic [DATA_W-1:0] pc_o, rsdata_o, rtdata_o, imm_o;
   logic [5:0]        funct_o;
   logic [REG_AW-1:0] rsaddr_o, rtaddr_o, rdaddr_o;
   logic              hazard_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   // reference state
   logic              m_valid;
   logic [1:0]        m_wb, m_mem;
   logic [3:0]        m_ex;
   logic [DATA_W-1:0] m_pc, m_rs, m_rt, m_imm;
   logic [REG_AW-1:0] m_rsa, m_rta, m_rda;
   int                m_cnt;

   int n_checks = 0;
   int n_err    = 0;

   id_ex_stage #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(vld),
      .wb_i(wb), .mem_i(mem), .ex_i(ex), .pc_i(pc), .rsdata_i(rsd), .rtdata_i(rtd),
      .imm_i(imm), .rsaddr_i(rsa), .rtaddr_i(rta), .rdaddr_i(rda),
      .wb_we_i(we), .wb_addr_i(wa), .wb_data_i(wd),
      .valid_o(valid_o), .wb_o(wb_o), .mem_o(mem_o), .ex_o(ex_o), .pc_o(pc_o),
      .rsdata_o(rsdata_o), .rtdata_o(rtdata_o), .imm_o(imm_o), .funct_o(funct_o),
      .rsaddr_o(rsaddr_o), .rtaddr_o(rtaddr_o), .rdaddr_o(rdaddr_o),
      .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_haz();
      return m_valid && m_mem[0] && (m_rta != 0) && vld && ((m_rta == rsa) || (m_rta == rta));
   endfunction

   task automatic model_reset();
      m_valid = 0; m_wb = 0; m_mem = 0; m_ex = 0; m_pc = 0; m_rs = 0; m_rt = 0;
      m_imm = 0; m_rsa = 0; m_rta = 0; m_rda = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic haz);
      if (flush || (!stall && haz)) begin
         m_valid = 0; m_wb = 0; m_mem = 0; m_ex = 0;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else if (stall) begin
         if (m_valid && we && wa != 0) begin
            if (wa == m_rsa) m_rs = wd;
            if (wa == m_rta) m_rt = wd;
         end
      end else begin
         m_valid = vld;
         m_wb  = vld ? wb  : 2'b0;
         m_mem = vld ? mem : 2'b0;
         m_ex  = vld ? ex  : 4'b0;
         m_pc = pc; m_imm = imm; m_rsa = rsa; m_rta = rta; m_rda = rda;
         m_rs = (we && wa != 0 && wa == rsa) ? wd : rsd;
         m_rt = (we && wa != 0 && wa == rta) ? wd : rtd;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":valid"},  valid_o,  m_valid);
      chk({tag, ":wb"},     wb_o,     m_wb);
      chk({tag, ":mem"},    mem_o,    m_mem);
      chk({tag, ":ex"},     ex_o,     m_ex);
      chk({tag, ":pc"},     pc_o,     m_pc);
      chk({tag, ":rsdata"}, rsdata_o, m_rs);
      chk({tag, ":rtdata"}, rtdata_o, m_rt);
      chk({tag, ":imm"},    imm_o,    m_imm);
      chk({tag, ":funct"},  funct_o,  m_imm[5:0]);
      chk({tag, ":rsaddr"}, rsaddr_o, m_rsa);
      chk({tag, ":rtaddr"}, rtaddr_o, m_rta);
      chk({tag, ":rdaddr"}, rdaddr_o, m_rda);
      chk({tag, ":cnt"},    bubble_cnt_o, m_cnt);
   endtask

   // Inputs are already set; check hazard, advance model, clock, check outputs.
   task automatic step(input string tag);
      logic haz;
      #1;
      haz = model_haz();
      chk({tag, ":hazard"}, hazard_o, haz);
      model_edge(haz);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic quiet();
      stall = 0; flush = 0; vld = 1; wb = 2'b01; mem = 2'b00; ex = 4'h3;
      pc = $urandom; rsd = $urandom; rtd = $urandom; imm = $urandom;
      rsa = 5'd1; rta = 5'd2; rda = 5'd3; we = 0; wa = 0; wd = 0;
   endtask

   task automatic rand_in();
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      vld   = ($urandom_range(0, 3) != 0);
      wb = 2'($urandom); mem = 2'($urandom); ex = 4'($urandom);
      pc = $urandom; rsd = $urandom; rtd = $urandom; imm = $urandom;
      rsa = 5'($urandom_range(0, 3)); rta = 5'($urandom_range(0, 3));
      rda = 5'($urandom);
      we = $urandom_range(0, 1); wa = 5'($urandom_range(0, 3)); wd = $urandom;
   endtask

   initial begin
      int c0;
      rst_n = 0;
      quiet();
      model_reset();
      #12;
      rst_n = 1;
      @(negedge clk);

      // reset: inputs nonzero, pulse low between edges
      quiet();
      vld = 1; mem = 2'b11; ex = 4'hF; wb = 2'b11; rsa = 5'd9; rta = 5'd9; rda = 5'd9;
      step("pre_rst");
      @(negedge clk);
      #1 rst_n = 0;
      #1;
      model_reset();
      check_all("rst");
      chk("rst:hazard", hazard_o, 1'b0);
      @(negedge clk);
      rst_n = 1;
      quiet();
      pc = 32'h40;
      step("rst_first");
      chk("rst_first:pc40", pc_o, 32'h40);
      chk("rst_first:valid1", valid_o, 1'b1);

      // load-use hazard
      quiet(); mem = 2'b01; rta = 5'd5;
      step("lu_ld");
      quiet(); rsa = 5'd5; rta = 5'd6; ex = 4'hA;
      #1 chk("lu:hazard1", hazard_o, 1'b1);
      c0 = m_cnt;
      step("lu_bubble");
      chk("lu_bubble:valid0", valid_o, 1'b0);
      chk("lu_bubble:ex0", ex_o, 4'h0);
      chk("lu_bubble:cnt", bubble_cnt_o, c0 + 1);
      step("lu_load");
      chk("lu_load:valid1", valid_o, 1'b1);
      chk("lu_load:ex", ex_o, 4'hA);
      // load targeting r0 never hazards
      quiet(); mem = 2'b01; rta = 5'd0;
      step("lu0_ld");
      quiet(); rsa = 5'd0; rta = 5'd0;
      #1 chk("lu0:hazard0", hazard_o, 1'b0);
      step("lu0_next");

      // stall hold with changing inputs
      c0 = m_cnt;
      for (int i = 0; i < 3; i++) begin
         rand_in(); stall = 1; flush = 0; we = 0;
         step("stall");
      end
      chk("stall:cnt", bubble_cnt_o, c0);

      // bypass on load, on hold, and address 0
      quiet(); rsa = 5'd7; rsd = 32'h11; rta = 5'd9; we = 1; wa = 5'd7; wd = 32'hAB;
      step("byp_ld");
      chk("byp_ld:rs", rsdata_o, 32'hAB);
      quiet(); stall = 1; we = 1; wa = 5'd9; wd = 32'hCD;
      step("byp_hold");
      chk("byp_hold:rt", rtdata_o, 32'hCD);
      quiet(); rta = 5'd0; rtd = 32'h55; we = 1; wa = 5'd0; wd = 32'h99;
      step("byp_zero");
      chk("byp_zero:rt", rtdata_o, 32'h55);

      // priority: flush+stall+hazard gives one bubble
      quiet(); mem = 2'b01; rta = 5'd5;
      step("pri_ld");
      quiet(); rsa = 5'd5; stall = 1; flush = 1;
      c0 = m_cnt;
      step("pri_flush");
      chk("pri_flush:cnt", bubble_cnt_o, (c0 + 1 > CNT_MAX) ? CNT_MAX : c0 + 1);
      chk("pri_flush:valid", valid_o, 1'b0);
      // stall with hazard holds, then one bubble on release
      quiet(); mem = 2'b01; rta = 5'd5;
      step("pri_ld2");
      quiet(); rsa = 5'd5; stall = 1;
      c0 = m_cnt;
      step("pri_stall");
      chk("pri_stall:valid", valid_o, 1'b1);
      chk("pri_stall:cnt", bubble_cnt_o, c0);
      #1 chk("pri_stall:hazard", hazard_o, 1'b1);
      stall = 0;
      step("pri_release");
      chk("pri_release:valid", valid_o, 1'b0);

      // saturation with a 2-bit counter
      @(negedge clk);
      rst_n = 0;
      #1 model_reset();
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         quiet(); flush = 1;
         step("sat");
         chk($sformatf("sat%0d", i), bubble_cnt_o, (i + 1 > 3) ? 3 : i + 1);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rand_in();
         step($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
